seq_frame_tx: RTL and testbench

- Serial frame transmitter that generates the bit stream consumed by the team's Mealy "1011" sequence detector.
- Accepts one parallel data word per valid/ready handshake. Emits a fixed preamble (default 1011) MSB-first, then the data word MSB-first, then a forced-low guard gap.
- Sits upstream of the detector's single-bit input `x`; tx_bit drives `x` directly in loopback test setups.

---
 rtl/seq_frame_tx.sv | 67 ++++++
 tb/tb_seq_frame_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter sending a preamble, the payload MSB-first, then a low guard gap
module seq_frame_tx #(
  parameter int DATA_W = 8,
  parameter int PRE_W = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b1011,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              done
);
  localparam int MX = PRE_W > DATA_W ? (PRE_W > GAP_CYC ? PRE_W : GAP_CYC) : (DATA_W > GAP_CYC ? DATA_W : GAP_CYC);
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam int PW = 1 << CW;
  localparam logic [PW-1:0] PRE_EXT = PW'(PREAMBLE);
  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic last;
  assign last = cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    case (state)
      IDLE: begin
        state_nx = start_valid ? PRE : IDLE;
        cnt_nx   = start_valid ? CW'(PRE_W - 1) : cnt;
        shreg_nx = start_valid ? data_in : shreg;
      end
      PRE: begin
        state_nx = last ? DATA : PRE;
        cnt_nx   = last ? CW'(DATA_W - 1) : cnt - CW'(1);
      end
      DATA: begin
        state_nx = last ? GAP : DATA;
        cnt_nx   = last ? CW'(GAP_CYC - 1) : cnt - CW'(1);
        shreg_nx = shreg << 1;
      end
      default: begin
        state_nx = last ? IDLE : GAP;
        cnt_nx   = last ? cnt : cnt - CW'(1);
      end
    endcase
  end
  assign tx_en       = state == PRE || state == DATA;
  assign tx_bit      = state == PRE ? PRE_EXT[cnt] : state == DATA && shreg[DATA_W-1];
  assign done        = state == GAP && cnt == CW'(GAP_CYC - 1);
  assign start_ready = state == IDLE && !rst;
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: randomized self-checking bench for seq_frame_tx with a frame-level reference model
module tb_seq_frame_tx;
  logic clk, rst, start_valid, start_ready, tx_bit, tx_en, done;
  logic [7:0] data_in;
  int checks = 0;
  int failures = 0;

  seq_frame_tx dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .data_in(data_in), .tx_bit(tx_bit), .tx_en(tx_en), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_bits(input logic [7:0] d);
    return {4'b1011, d};
  endfunction

  // a 1011 detector sees the frame bits followed by low gap/idle bits, with zeros before
  function automatic logic [15:0] exp_zmask(input logic [7:0] d);
    logic [14:0] s;
    logic [15:0] m;
    logic [3:0] w;
    s = {exp_bits(d), 3'b000};
    m = '0;
    w = '0;
    for (int c = 1; c <= 15; c++) begin
      w = {w[2:0], s[15-c]};
      if (w == 4'b1011) m[c] = 1'b1;
    end
    return m;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!start_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_timeout start_ready=%b required=1", start_ready);
    end
  endtask

  task automatic capture_frame(input logic [7:0] d, input int busy_cyc, output logic [11:0] bits,
                               output int n_en, output int n_done, output int done_c,
                               output int ready_c, output logic [15:0] zmask);
    logic [3:0] hist = '0;
    bits = '0; n_en = 0; n_done = 0; done_c = 0; ready_c = 0; zmask = '0;
    start_valid = 1; data_in = d;
    tick();
    start_valid = 0;
    for (int c = 1; c <= 30; c++) begin
      start_valid = c == busy_cyc;
      data_in = c == busy_cyc ? 8'h00 : 8'($urandom);
      if (tx_en) begin
        bits = {bits[10:0], tx_bit};
        n_en++;
      end
      if (done) begin
        n_done++;
        if (done_c == 0) done_c = c;
      end
      if (start_ready && ready_c == 0) ready_c = c;
      hist = {hist[2:0], tx_bit};
      if (hist == 4'b1011 && c <= 15) zmask[c] = 1'b1;
      tick();
    end
    start_valid = 0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic [11:0] bits,
                             input int n_en, input int n_done, input int done_c, input int ready_c);
    checks += 5;
    if (bits !== exp_bits(d)) begin
      failures++;
      $display("FAIL %s_bits data=%h got=%b required=%b", name, d, bits, exp_bits(d));
    end
    if (n_en !== 12) begin
      failures++;
      $display("FAIL %s_en_cycles got=%0d required=12", name, n_en);
    end
    if (n_done !== 1) begin
      failures++;
      $display("FAIL %s_done_count got=%0d required=1", name, n_done);
    end
    if (done_c !== 13) begin
      failures++;
      $display("FAIL %s_done_cycle got=%0d required=13", name, done_c);
    end
    if (ready_c !== 14) begin
      failures++;
      $display("FAIL %s_ready_cycle got=%0d required=14", name, ready_c);
    end
  endtask

  task automatic test_reset();
    rst = 1; start_valid = 0; data_in = 8'h00;
    #1;
    checks++;
    if ({tx_bit, tx_en, done, start_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0000", {tx_bit, tx_en, done, start_ready});
    end
    start_valid = 1;
    tick();
    tick();
    checks++;
    if ({tx_en, start_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_no_accept got=%b required=00", {tx_en, start_ready});
    end
    start_valid = 0;
    #2 rst = 0;
    #1;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b required=1", start_ready);
    end
    start_valid = 1; data_in = 8'hA5;
    tick();
    start_valid = 0;
    tick();
    #2 rst = 1;
    #1;
    checks++;
    if ({tx_bit, tx_en, done, start_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async_outputs got=%b required=0000", {tx_bit, tx_en, done, start_ready});
    end
    tick();
    #2 rst = 0;
    tick();
  endtask

  task automatic test_single();
    logic [11:0] b; logic [15:0] z; int ne, nd, dc, rc;
    wait_idle();
    capture_frame(8'hA5, 0, b, ne, nd, dc, rc, z);
    check_frame("single", 8'hA5, b, ne, nd, dc, rc);
    checks++;
    if (b !== 12'b1011_1010_0101) begin
      failures++;
      $display("FAIL single_literal got=%b required=101110100101", b);
    end
  endtask

  task automatic test_random();
    logic [11:0] b; logic [15:0] z; int ne, nd, dc, rc; logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      wait_idle();
      d = 8'($urandom);
      capture_frame(d, 0, b, ne, nd, dc, rc, z);
      check_frame("random", d, b, ne, nd, dc, rc);
      checks++;
      if (z !== exp_zmask(d)) begin
        failures++;
        $display("FAIL random_detect data=%h got=%h required=%h", d, z, exp_zmask(d));
      end
    end
  endtask

  task automatic test_back_to_back();
    int s1 = 0, s2 = 0, n1 = 0, n2 = 0;
    logic prev = 0, g13 = 1, g27 = 1;
    logic [11:0] b1 = '0, b2 = '0;
    wait_idle();
    start_valid = 1; data_in = 8'h3C;
    tick();
    data_in = 8'hFF;
    for (int c = 1; c <= 30; c++) begin
      if (tx_en && !prev) begin
        if (s1 == 0) s1 = c;
        else if (s2 == 0) s2 = c;
      end
      if (s2 != 0) start_valid = 0;
      if (tx_en && s2 == 0 && n1 < 12) begin b1 = {b1[10:0], tx_bit}; n1++; end
      if (tx_en && s2 != 0 && n2 < 12) begin b2 = {b2[10:0], tx_bit}; n2++; end
      if (c == 13) g13 = tx_bit | tx_en;
      if (c == 27) g27 = tx_bit | tx_en;
      prev = tx_en;
      tick();
    end
    start_valid = 0;
    checks += 6;
    if (s1 !== 1) begin failures++; $display("FAIL b2b_first_start got=%0d required=1", s1); end
    if (s2 - s1 !== 14) begin failures++; $display("FAIL b2b_period got=%0d required=14", s2 - s1); end
    if (b1 !== exp_bits(8'h3C)) begin failures++; $display("FAIL b2b_frame1 got=%b required=%b", b1, exp_bits(8'h3C)); end
    if (b2 !== exp_bits(8'hFF)) begin failures++; $display("FAIL b2b_frame2 got=%b required=%b", b2, exp_bits(8'hFF)); end
    if (g13 !== 1'b0) begin failures++; $display("FAIL b2b_gap1 got=%b required=0", g13); end
    if (g27 !== 1'b0) begin failures++; $display("FAIL b2b_gap2 got=%b required=0", g27); end
  endtask

  task automatic test_busy_ignore();
    logic [11:0] b; logic [15:0] z; int ne, nd, dc, rc;
    wait_idle();
    capture_frame(8'hA5, 5, b, ne, nd, dc, rc, z);
    check_frame("busy", 8'hA5, b, ne, nd, dc, rc);
  endtask

  task automatic test_loopback();
    logic [11:0] b; logic [15:0] z; int ne, nd, dc, rc;
    wait_idle();
    capture_frame(8'hB0, 0, b, ne, nd, dc, rc, z);
    checks++;
    if (z !== 16'h0110) begin failures++; $display("FAIL loop_b0 got=%h required=0110", z); end
    wait_idle();
    capture_frame(8'h00, 0, b, ne, nd, dc, rc, z);
    checks++;
    if (z !== 16'h0010) begin failures++; $display("FAIL loop_00 got=%h required=0010", z); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] b; logic [15:0] z; int ne, nd, dc, rc, nd_rst = 0;
    wait_idle();
    start_valid = 1; data_in = 8'hA5;
    tick();
    start_valid = 0;
    repeat (6) tick();
    checks++;
    if ({tx_en, tx_bit} !== 2'b11) begin
      failures++;
      $display("FAIL mid_third_data_bit got=%b required=11", {tx_en, tx_bit});
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({tx_bit, tx_en, done, start_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_abort got=%b required=0000", {tx_bit, tx_en, done, start_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) nd_rst++;
    end
    #2 rst = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) nd_rst++;
      tick();
    end
    checks++;
    if (nd_rst !== 0) begin failures++; $display("FAIL mid_no_done got=%0d required=0", nd_rst); end
    capture_frame(8'hA5, 0, b, ne, nd, dc, rc, z);
    check_frame("after_reset", 8'hA5, b, ne, nd, dc, rc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_loopback();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
